// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose:
//   Generates the hold / bubble / flush controls for the IF/ID and ID/EX
//   pipeline buffers. The decode-stage instruction is compared against the
//   instruction currently issuing from ID/EX to detect load-use hazards.
//   Data-memory wait states hold the whole pipe, and a taken branch flushes
//   IF/ID. A saturating counter tracks the number of cycles the PC was held.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous reset, active-high
//   i_id_instruction  instruction in ID (IF/ID output)
//   i_ex_instruction  instruction issuing from ID/EX (bubble = 0)
//   i_ex_mem_ctrl     ID/EX memory control: [2]=cs_n, [1]=we, [0]=reserved
//   i_ex_wb_ctrl      ID/EX writeback control: [0]=register write enable
//   i_mem_busy        data memory not ready, hold the whole pipe
//   i_branch_taken    branch resolved taken in EX this cycle
//   o_pc_hold         hold the PC
//   o_stall_if_id     hold IF/ID contents
//   o_stall_id_ex     ID/EX stall (bubble out, hold saved)
//   o_flush_if_id     clear IF/ID to NOP on the next edge
//   o_state           FSM state for debug
//   o_stall_count     saturating count of cycles with o_pc_hold=1
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int unsigned STALL_CYCLES = 1,
   parameter int unsigned RN_LSB       = 16,
   parameter int unsigned RM_LSB       = 0,
   parameter int unsigned RD_LSB       = 12,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_id_instruction,
   input  logic [31:0]      i_ex_instruction,
   input  logic [2:0]       i_ex_mem_ctrl,
   input  logic [2:0]       i_ex_wb_ctrl,
   input  logic             i_mem_busy,
   input  logic             i_branch_taken,
   output logic             o_pc_hold,
   output logic             o_stall_if_id,
   output logic             o_stall_id_ex,
   output logic             o_flush_if_id,
   output logic [1:0]       o_state,
   output logic [CNT_W-1:0] o_stall_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      LOAD_STALL = 2'd1,
      MEM_WAIT   = 2'd2,
      FLUSH      = 2'd3
   } state_t;

   // The RUN-state stall already covers the first cycle, so the down-counter
   // only needs to cover the remaining cycles of the load-use stall.
   localparam bit       MULTI_CYCLE = (STALL_CYCLES > 1);
   localparam logic [3:0] LOAD_CNT  = 4'(STALL_CYCLES - 1);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic             r_mask;
   logic [CNT_W-1:0] r_stallCount;

   logic [3:0] w_rd;
   logic [3:0] w_rn;
   logic [3:0] w_rm;
   logic       w_exLoad;
   logic       w_exValid;
   logic       w_hazard;
   logic       w_stall;
   logic       w_flush;
   logic       w_unused;

   // Register fields of the two instructions being compared.
   assign w_rd = i_ex_instruction[RD_LSB +: 4];
   assign w_rn = i_id_instruction[RN_LSB +: 4];
   assign w_rm = i_id_instruction[RM_LSB +: 4];

   // A load is a selected memory access that is not a write. A bubble
   // (all-zero instruction) would otherwise match register 0 on every field,
   // so it is excluded explicitly.
   assign w_exLoad  = !i_ex_mem_ctrl[2] & !i_ex_mem_ctrl[1];
   assign w_exValid = |i_ex_instruction;
   assign w_hazard  = !i_rst & w_exLoad & w_exValid & i_ex_wb_ctrl[0] & !r_mask
                      & ((w_rd == w_rn) | (w_rd == w_rm));

   // Bits that do not take part in the decision are gathered here.
   assign w_unused = ^{i_id_instruction, i_ex_mem_ctrl[0], i_ex_wb_ctrl[2:1]};

   // Output decode. The load-use stall and the branch flush must take effect
   // in the same cycle they are seen, so RUN looks at the live inputs; the
   // other states are decoded from the state register (plus mem_busy while
   // waiting on memory). While reset is held everything reads zero.
   always_comb begin
      w_stall = 1'b0;
      w_flush = 1'b0;
      case (r_state)
         RUN: begin
            if (!i_rst && !i_mem_busy) begin
               if (i_branch_taken) begin
                  w_flush = 1'b1;
               end else if (w_hazard) begin
                  w_stall = 1'b1;
               end
            end
         end
         LOAD_STALL: begin
            w_stall = 1'b1;
         end
         MEM_WAIT: begin
            w_stall = i_mem_busy;
         end
         FLUSH: begin
            w_flush = 1'b1;
         end
         default: begin
            w_stall = 1'b0;
            w_flush = 1'b0;
         end
      endcase
   end

   // State machine, load-use down-counter, one-cycle hazard mask and the
   // saturating stall counter. The mask defaults to clear on every edge so
   // it only ever covers the single RUN cycle after a load-use stall, in
   // which the re-issued consumer still sees the same ID/EX fields.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= RUN;
         r_cnt        <= 4'd0;
         r_mask       <= 1'b0;
         r_stallCount <= '0;
      end else begin
         r_mask <= 1'b0;

         if (w_stall && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + 1'b1;
         end

         case (r_state)
            RUN: begin
               if (i_mem_busy) begin
                  r_state <= MEM_WAIT;
               end else if (i_branch_taken) begin
                  r_state <= FLUSH;
               end else if (w_hazard) begin
                  if (MULTI_CYCLE) begin
                     r_cnt   <= LOAD_CNT;
                     r_state <= LOAD_STALL;
                  end else begin
                     r_mask <= 1'b1;
                  end
               end
            end
            LOAD_STALL: begin
               if (i_mem_busy) begin
                  r_cnt   <= 4'd0;
                  r_state <= MEM_WAIT;
               end else if (r_cnt == 4'd1) begin
                  r_cnt   <= 4'd0;
                  r_mask  <= 1'b1;
                  r_state <= RUN;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            MEM_WAIT: begin
               if (!i_mem_busy) begin
                  r_state <= RUN;
               end
            end
            FLUSH: begin
               r_state <= i_mem_busy ? MEM_WAIT : RUN;
            end
            default: begin
               r_state <= RUN;
            end
         endcase
      end
   end

   assign o_pc_hold     = w_stall;
   assign o_stall_if_id = w_stall;
   assign o_stall_id_ex = w_stall;
   assign o_flush_if_id = w_flush;
   assign o_state       = r_state;
   assign o_stall_count = r_stallCount;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Purpose:
//   Self-checking bench for hazard_stall_ctrl. Three instances with different
//   parameters share one set of inputs; the instance under test is selected
//   per phase. Expected values are pushed to a queue when stimulus is driven
//   and popped/compared when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] idInstr;
   logic [31:0] exInstr;
   logic [2:0]  memCtrl;
   logic [2:0]  wbCtrl;
   logic        memBusy;
   logic        branchTaken;

   logic        pc1, sif1, sie1, fl1;
   logic [1:0]  st1;
   logic [15:0] cnt1;
   logic        pc3, sif3, sie3, fl3;
   logic [1:0]  st3;
   logic [15:0] cnt3;
   logic        pc4, sif4, sie4, fl4;
   logic [1:0]  st4;
   logic [3:0]  cnt4;

   typedef struct {
      string       tag;
      logic [5:0]  ctrl;
      logic [15:0] cnt;
   } expT;

   expT sb[$];
   int  compared   = 0;
   int  mismatched = 0;
   int  dutSel     = 1;

   logic [31:0] exLoad3;
   logic [31:0] idRn3;
   logic [31:0] idRm3;
   logic [31:0] idNone;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   hazard_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_id_instruction(idInstr), .i_ex_instruction(exInstr),
      .i_ex_mem_ctrl(memCtrl), .i_ex_wb_ctrl(wbCtrl),
      .i_mem_busy(memBusy), .i_branch_taken(branchTaken),
      .o_pc_hold(pc1), .o_stall_if_id(sif1), .o_stall_id_ex(sie1),
      .o_flush_if_id(fl1), .o_state(st1), .o_stall_count(cnt1)
   );

   hazard_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut3 (
      .i_clk(clk), .i_rst(rst),
      .i_id_instruction(idInstr), .i_ex_instruction(exInstr),
      .i_ex_mem_ctrl(memCtrl), .i_ex_wb_ctrl(wbCtrl),
      .i_mem_busy(memBusy), .i_branch_taken(branchTaken),
      .o_pc_hold(pc3), .o_stall_if_id(sif3), .o_stall_id_ex(sie3),
      .o_flush_if_id(fl3), .o_state(st3), .o_stall_count(cnt3)
   );

   hazard_stall_ctrl #(.STALL_CYCLES(4), .CNT_W(4)) dut4 (
      .i_clk(clk), .i_rst(rst),
      .i_id_instruction(idInstr), .i_ex_instruction(exInstr),
      .i_ex_mem_ctrl(memCtrl), .i_ex_wb_ctrl(wbCtrl),
      .i_mem_busy(memBusy), .i_branch_taken(branchTaken),
      .o_pc_hold(pc4), .o_stall_if_id(sif4), .o_stall_id_ex(sie4),
      .o_flush_if_id(fl4), .o_state(st4), .o_stall_count(cnt4)
   );

   // Builds an instruction word with rd at [15:12], rn at [19:16], rm at [3:0]
   // and some unrelated opcode bits set.
   function automatic logic [31:0] makeInstr(logic [3:0] rd, logic [3:0] rn, logic [3:0] rm);
      return 32'hE000_0000 | (32'(rn) << 16) | (32'(rd) << 12) | 32'(rm);
   endfunction

   // Expected control vector: {state, pc_hold, stall_if_id, stall_id_ex, flush}.
   function automatic logic [5:0] ctrlVec(logic [1:0] st, logic stall, logic fl);
      return {st, stall, stall, stall, fl};
   endfunction

   // Single comparison point: counts and reports any mismatch.
   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Pops the oldest expectation and compares it to the selected instance.
   task automatic sampleOutputs();
      expT         e;
      logic [5:0]  obsCtrl;
      logic [15:0] obsCnt;
      if (sb.size() == 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      case (dutSel)
         1:       begin obsCtrl = {st1, pc1, sif1, sie1, fl1}; obsCnt = cnt1; end
         3:       begin obsCtrl = {st3, pc3, sif3, sie3, fl3}; obsCnt = cnt3; end
         default: begin obsCtrl = {st4, pc4, sif4, sie4, fl4}; obsCnt = {12'd0, cnt4}; end
      endcase
      checkOutput({e.tag, ".ctrl"}, 32'(obsCtrl), 32'(e.ctrl));
      checkOutput({e.tag, ".cnt"},  32'(obsCnt),  32'(e.cnt));
   endtask

   task automatic pushExpect(string tag, logic [1:0] st, logic stall, logic fl, logic [15:0] cnt);
      expT e;
      e.tag  = tag;
      e.ctrl = ctrlVec(st, stall, fl);
      e.cnt  = cnt;
      sb.push_back(e);
   endtask

   // Drives one cycle of inputs on the falling edge, records the expectation
   // and samples the outputs before the next rising edge.
   task automatic applyStimulus(string tag, logic r, logic [31:0] idI, logic [31:0] exI,
                                logic [2:0] mc, logic [2:0] wc, logic busy, logic br,
                                logic [1:0] st, logic stall, logic fl, logic [15:0] cnt);
      @(negedge clk);
      rst         = r;
      idInstr     = idI;
      exInstr     = exI;
      memCtrl     = mc;
      wbCtrl      = wc;
      memBusy     = busy;
      branchTaken = br;
      pushExpect(tag, st, stall, fl, cnt);
      #2;
      sampleOutputs();
   endtask

   task automatic idleStep(string tag, logic [1:0] st, logic stall, logic fl, logic [15:0] cnt);
      applyStimulus(tag, 1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b0, 1'b0, st, stall, fl, cnt);
   endtask

   task automatic resetPhase(string tag);
      applyStimulus({tag, ".rst"}, 1'b1, 32'd0, 32'd0, 3'b100, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
      idleStep({tag, ".rel"}, 2'd0, 1'b0, 1'b0, 16'd0);
   endtask

   initial begin
      rst         = 1'b1;
      idInstr     = 32'd0;
      exInstr     = 32'd0;
      memCtrl     = 3'b100;
      wbCtrl      = 3'b000;
      memBusy     = 1'b0;
      branchTaken = 1'b0;

      exLoad3 = makeInstr(4'd3, 4'd9, 4'd10);
      idRn3   = makeInstr(4'd7, 4'd3, 4'd5);
      idRm3   = makeInstr(4'd7, 4'd8, 4'd3);
      idNone  = makeInstr(4'd3, 4'd8, 4'd5);

      // Reset held with random inputs, checked on every instance.
      for (int i = 0; i < 3; i++) begin
         dutSel = (i == 0) ? 1 : ((i == 1) ? 3 : 4);
         applyStimulus("t1.rsthold", 1'b1, $urandom, $urandom, 3'($urandom), 3'($urandom),
                       1'($urandom), 1'($urandom), 2'd0, 1'b0, 1'b0, 16'd0);
      end
      dutSel = 1;
      applyStimulus("t1.hazardInRst", 1'b1, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b1,
                    2'd0, 1'b0, 1'b0, 16'd0);
      idleStep("t1.release", 2'd0, 1'b0, 1'b0, 16'd0);
      idleStep("t1.idle0",   2'd0, 1'b0, 1'b0, 16'd0);
      idleStep("t1.idle1",   2'd0, 1'b0, 1'b0, 16'd0);

      // Single-cycle load-use stall, then one masked cycle, then re-detect.
      dutSel = 1;
      resetPhase("t2");
      applyStimulus("t2.stall",  1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
      applyStimulus("t2.masked", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd1);
      applyStimulus("t2.again",  1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd1);
      idleStep("t2.idle", 2'd0, 1'b0, 1'b0, 16'd2);

      // Three-cycle load-use stall on an rm match, then non-hazard patterns.
      dutSel = 3;
      resetPhase("t3");
      applyStimulus("t3.run",    1'b0, idRm3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
      applyStimulus("t3.ls1",    1'b0, idRm3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd1);
      applyStimulus("t3.ls2",    1'b0, idRm3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd2);
      applyStimulus("t3.masked", 1'b0, idRm3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      idleStep("t3.idle", 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.csn",    1'b0, idRm3, exLoad3, 3'b100, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.csn2",   1'b0, idRm3, exLoad3, 3'b100, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.store",  1'b0, idRm3, exLoad3, 3'b010, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.noWb",   1'b0, idRm3, exLoad3, 3'b000, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.noMatch",1'b0, idNone, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);
      applyStimulus("t3.bubble", 1'b0, 32'd0, 32'd0, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd3);

      // mem_busy beats branch and hazard; stall held while busy stays high.
      dutSel = 1;
      resetPhase("t4");
      applyStimulus("t4.run", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus("t4.wait", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b1, 1'b1,
                       2'd2, 1'b1, 1'b0, 16'(k));
      end
      applyStimulus("t4.done", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'd4);
      idleStep("t4.idle", 2'd0, 1'b0, 1'b0, 16'd4);

      // Branch flush, then a flush that runs into a memory wait.
      dutSel = 1;
      resetPhase("t5");
      applyStimulus("t5.br",     1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'd0);
      idleStep("t5.flush", 2'd3, 1'b0, 1'b1, 16'd0);
      idleStep("t5.run",   2'd0, 1'b0, 1'b0, 16'd0);
      applyStimulus("t5.br2",    1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 16'd0);
      applyStimulus("t5.flBusy", 1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 16'd0);
      applyStimulus("t5.wait",   1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 16'd0);
      idleStep("t5.done", 2'd2, 1'b0, 1'b0, 16'd1);
      idleStep("t5.idle", 2'd0, 1'b0, 1'b0, 16'd1);

      // Reset pulse in the second cycle of a four-cycle load-use stall.
      dutSel = 4;
      resetPhase("t6");
      applyStimulus("t6.run", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
      applyStimulus("t6.ls1", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 16'd1);
      rst = 1'b1;
      pushExpect("t6.asyncRst", 2'd0, 1'b0, 1'b0, 16'd0);
      #1;
      sampleOutputs();
      idleStep("t6.released", 2'd0, 1'b0, 1'b0, 16'd0);
      applyStimulus("t6.run2",   1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0);
      applyStimulus("t6.ls2a",   1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd1);
      applyStimulus("t6.ls2b",   1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd2);
      applyStimulus("t6.ls2c",   1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd3);
      applyStimulus("t6.masked", 1'b0, idRn3, exLoad3, 3'b000, 3'b001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd4);

      // Saturation of the 4-bit stall counter over 20 memory-wait cycles.
      resetPhase("t7");
      applyStimulus("t7.run", 1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus("t7.wait", 1'b0, 32'd0, 32'd0, 3'b100, 3'b000, 1'b1, 1'b0,
                       2'd2, 1'b1, 1'b0, (k - 1 > 15) ? 16'd15 : 16'(k - 1));
      end
      idleStep("t7.done", 2'd2, 1'b0, 1'b0, 16'd15);
      idleStep("t7.sat",  2'd0, 1'b0, 1'b0, 16'd15);

      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scoreboard: got %0d leftover entries, expected 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller that generates the hold/bubble/flush controls consumed by the IF/ID and ID/EX pipeline buffers. It compares the decode-stage instruction against the instruction and control currently issuing from ID/EX. It asserts stalls for load-use hazards and data-memory wait states, and flushes IF/ID on taken branches. It also keeps a saturating count of stall cycles for performance debug.

Parameters:
STALL_CYCLES, 1, total load-use stall length in cycles (1..15)
RN_LSB, 16, LSB of 4-bit first source register field
RM_LSB, 0, LSB of 4-bit second source register field
RD_LSB, 12, LSB of 4-bit destination register field
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
id_instruction  in  32  instruction currently in ID (IF/ID output)
ex_instruction  in  32  instruction issuing from ID/EX (bubble = 0)
ex_mem_ctrl  in  3  ID/EX mem control: [2]=cs_n, [1]=we, [0]=reserved
ex_wb_ctrl  in  3  ID/EX writeback control: [0]=reg write enable
mem_busy  in  1  data memory not ready, hold whole pipe
branch_taken  in  1  branch resolved taken in EX this cycle
pc_hold  out  1  hold PC
stall_if_id  out  1  hold IF/ID contents
stall_id_ex  out  1  drive ID/EX stall (bubble out, hold saved)
flush_if_id  out  1  clear IF/ID to NOP on next edge
state  out  2  FSM state for debug
stall_count  out  CNT_W  saturating count of cycles with pc_hold=1

Behaviour:
- Reset (rst=1, async): state=RUN(2'd0), stall_count=0, mask=0. All control outputs are combinational from state, so they read 0 while reset is held.
- ex_load = !ex_mem_ctrl[2] & !ex_mem_ctrl[1].
- hazard = ex_load & ex_wb_ctrl[0] & !mask & (rd==rn | rd==rm). Here rd, rn and rm are the 4-bit fields at the parameterised LSBs. ex_instruction==0 never produces a hazard.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3. Event priority is mem_busy > branch_taken > hazard.
- RUN:
  - mem_busy=1: all outputs are 0 this cycle. Next state MEM_WAIT.
  - else branch_taken=1: flush_if_id=1 combinationally. Next state FLUSH.
  - else hazard=1: pc_hold=stall_if_id=stall_id_ex=1 combinationally (Mealy, same cycle). If STALL_CYCLES>1, load cnt=STALL_CYCLES-1 and go to LOAD_STALL. Otherwise stay in RUN and set mask=1.
  - else: all outputs are 0.
- LOAD_STALL: pc_hold=stall_if_id=stall_id_ex=1. cnt decrements each edge. When cnt==1, go to RUN and set mask=1. mem_busy=1 overrides: go to MEM_WAIT and discard cnt. branch_taken is ignored here, since EX holds a bubble.
- MEM_WAIT: pc_hold=stall_if_id=stall_id_ex=1 while mem_busy=1. When mem_busy=0, outputs are 0 that cycle and the next state is RUN. branch_taken is ignored.
- FLUSH: flush_if_id=1 and pc_hold=0 for exactly one cycle, then RUN. mem_busy=1 in FLUSH still completes the flush and goes to MEM_WAIT next.
- mask is set only by the end of a load-use stall. It suppresses hazard detection for exactly the one following RUN cycle (the re-issued consumer sees the same ex fields), then clears.
- stall_count increments on every edge where pc_hold=1 and saturates at all-ones.
- Reset mid-stall returns to RUN immediately. The counter, mask and stall_count are cleared.
- Output latency: load-use stall is 0 cycles (Mealy). A flush triggered by branch is 0 cycles. A mem_busy stall starts 1 cycle after mem_busy rises.

Test Plan:
1. Reset hold: rst=1 with random inputs -> state=0, all outputs 0, stall_count=0. Release rst, idle inputs -> outputs stay 0.
2. Load-use, STALL_CYCLES=1: ex_mem_ctrl=3'b000, ex_wb_ctrl=3'b001, ex rd=4'd3, id rn=4'd3 -> pc_hold/stall_if_id/stall_id_ex=1 for exactly 1 cycle, then 0 for the next cycle despite unchanged inputs (mask), stall_count=1.
3. Load-use, STALL_CYCLES=3, rm match -> stall asserted 3 consecutive cycles (RUN, LOAD_STALL, LOAD_STALL), then state=0. Repeat with ex_mem_ctrl=3'b100 -> no stall.
4. Priority: mem_busy=1, branch_taken=1 and hazard all in RUN -> MEM_WAIT next, stall held 4 cycles while mem_busy stays high, then RUN. flush_if_id never asserted.
5. Branch: branch_taken=1 in RUN -> flush_if_id=1 that cycle and the next (FLUSH), pc_hold=0, then RUN.
6. Reset mid-LOAD_STALL (STALL_CYCLES=4, rst pulse in 2nd stall cycle) -> outputs drop asynchronously, state=0, stall_count=0. Saturation check with CNT_W=4: 20 MEM_WAIT cycles -> stall_count=15.
